// File: rtl/i2s_pkg.sv
// Constants and small helpers shared by the I2S transmitter and receiver.
package i2s_pkg;

   localparam int unsigned SLOT_WIDTH = 32;
   localparam int unsigned FRAME_BITS = 64;
   localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

   typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

   typedef enum logic {
      WS_LEFT  = 1'b0,
      WS_RIGHT = 1'b1
   } ws_e;

   // Upper half of the frame carries the right channel.
   function automatic ws_e ws_for_bit(input bit_cnt_t b);
      return ws_e'(b[BIT_CNT_W-1]);
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: produces sclk and a strobe in the cycle sclk falls.
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int unsigned SCLK_HALF = 16
) (
   input  logic clk_in,
   input  logic rst_in,
   output logic sclk_out,
   output logic fall_out
);

   localparam int unsigned     DIV_W    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;
   logic             term;

   always_comb begin
      term   = (div_q == DIV_LAST);
      div_d  = term ? '0 : div_q + 1'b1;
      sclk_d = term ? ~sclk_q : sclk_q;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_out = sclk_q;
   // Strobe is valid in the cycle whose edge takes sclk from 1 to 0.
   assign fall_out = term & sclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter with a one-deep holding buffer for stereo pairs.
module i2s_transmitter
   import i2s_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = 24,
   parameter int unsigned SCLK_HALF    = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [SAMPLE_WIDTH-1:0] left_in,
   input  logic [SAMPLE_WIDTH-1:0] right_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   output logic                    sclk_out,
   output logic                    ws_out,
   output logic                    sdata_out,
   output logic                    frame_start_out,
   output logic                    underrun_out
);

   localparam int unsigned SW          = SAMPLE_WIDTH;
   localparam bit_cnt_t    LEFT_FIRST  = bit_cnt_t'(1);
   localparam bit_cnt_t    LEFT_LAST   = bit_cnt_t'(SAMPLE_WIDTH);
   localparam bit_cnt_t    RIGHT_FIRST = bit_cnt_t'(SLOT_WIDTH + 1);
   localparam bit_cnt_t    RIGHT_LAST  = bit_cnt_t'(SLOT_WIDTH + SAMPLE_WIDTH);

   logic fall;

   bit_cnt_t        bit_q, bit_d, bit_nx;
   ws_e             ws_q, ws_d;
   logic            sdata_q, sdata_d;
   logic [SW-1:0]   lsr_q, lsr_d, rsr_q, rsr_d;
   logic [SW-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic            ready_q, ready_d;
   logic            fs_q, fs_d;
   logic            und_q, und_d;
   logic            load;

   i2s_clk_gen #(
      .SCLK_HALF (SCLK_HALF)
   ) u_clk_gen (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .sclk_out (sclk_out),
      .fall_out (fall)
   );

   always_comb begin
      bit_d    = bit_q;
      ws_d     = ws_q;
      sdata_d  = sdata_q;
      lsr_d    = lsr_q;
      rsr_d    = rsr_q;
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
      ready_d  = ready_q;
      fs_d     = 1'b0;
      und_d    = 1'b0;
      bit_nx   = bit_q + 1'b1;
      load     = fall && (bit_nx == '0);

      if (fall) begin
         bit_d   = bit_nx;
         ws_d    = ws_for_bit(bit_nx);
         sdata_d = 1'b0;
         if (load) begin
            fs_d = 1'b1;
            if (!ready_q) begin
               lsr_d   = hold_l_q;
               rsr_d   = hold_r_q;
               ready_d = 1'b1;
            end else begin
               lsr_d = '0;
               rsr_d = '0;
               und_d = 1'b1;
            end
         end else if (bit_nx >= LEFT_FIRST && bit_nx <= LEFT_LAST) begin
            sdata_d = lsr_q[SW-1];
            lsr_d   = lsr_q << 1;
         end else if (bit_nx >= RIGHT_FIRST && bit_nx <= RIGHT_LAST) begin
            sdata_d = rsr_q[SW-1];
            rsr_d   = rsr_q << 1;
         end
      end

      // Load above sees the pre-accept buffer state, so a pair arriving in
      // the load cycle of an empty buffer waits for the next frame.
      if (ready_q && valid_in) begin
         hold_l_d = left_in;
         hold_r_d = right_in;
         ready_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         bit_q    <= '1;
         ws_q     <= WS_RIGHT;
         sdata_q  <= 1'b0;
         lsr_q    <= '0;
         rsr_q    <= '0;
         hold_l_q <= '0;
         hold_r_q <= '0;
         ready_q  <= 1'b1;
         fs_q     <= 1'b0;
         und_q    <= 1'b0;
      end else begin
         bit_q    <= bit_d;
         ws_q     <= ws_d;
         sdata_q  <= sdata_d;
         lsr_q    <= lsr_d;
         rsr_q    <= rsr_d;
         hold_l_q <= hold_l_d;
         hold_r_q <= hold_r_d;
         ready_q  <= ready_d;
         fs_q     <= fs_d;
         und_q    <= und_d;
      end
   end

   assign ready_out       = ready_q;
   assign ws_out          = ws_q;
   assign sdata_out       = sdata_q;
   assign frame_start_out = fs_q;
   assign underrun_out    = und_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter with a small I2S receive model.
module tb_i2s_transmitter;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [23:0] left_in = '0;
   logic [23:0] right_in = '0;
   logic        valid_in = 1'b0;
   logic        ready_out, sclk_out, ws_out, sdata_out, frame_start_out, underrun_out;

   always #5 clk_in = ~clk_in;

   i2s_transmitter #(
      .SAMPLE_WIDTH (24),
      .SCLK_HALF    (16)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .left_in         (left_in),
      .right_in        (right_in),
      .valid_in        (valid_in),
      .ready_out       (ready_out),
      .sclk_out        (sclk_out),
      .ws_out          (ws_out),
      .sdata_out       (sdata_out),
      .frame_start_out (frame_start_out),
      .underrun_out    (underrun_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Receive model: samples on sclk rising edges, frames aligned on ws 1->0.
   int          cyc = 0, acc_cnt = 0, und_cnt = 0, fs_cnt = 0, rdy_hi_cnt = 0, frames = 0;
   int          idx = 0, last_rise = 0, last_wsf = 0, sclk_per = 0, ws_per = 0;
   logic        sclk_p = 1'b0, ws_p = 1'b1, ws_at_rise = 1'b1, started = 1'b0;
   logic [63:0] cap = '0, last_frame = '1;

   always @(posedge clk_in) begin
      cyc++;
      if (!rst_in) begin
         started = 1'b0; idx = 0; last_rise = 0; last_wsf = 0;
         sclk_p = 1'b0; ws_p = 1'b1; ws_at_rise = 1'b1;
      end else begin
         if (valid_in && ready_out) acc_cnt++;
         if (underrun_out) und_cnt++;
         if (frame_start_out) fs_cnt++;
         if (ready_out) rdy_hi_cnt++;
         if (sclk_out && !sclk_p) begin
            if (last_rise != 0) sclk_per = cyc - last_rise;
            last_rise = cyc;
            if (!ws_out && ws_at_rise) begin
               idx = 0; started = 1'b1;
            end else if (idx < 63) idx++;
            ws_at_rise = ws_out;
            cap[idx] = sdata_out;
            if (started && idx == 63) begin
               last_frame = cap;
               frames++;
            end
         end
         if (!ws_out && ws_p) begin
            if (last_wsf != 0) ws_per = cyc - last_wsf;
            last_wsf = cyc;
         end
         sclk_p = sclk_out;
         ws_p   = ws_out;
      end
   end

   function automatic logic [23:0] get_left(input logic [63:0] f);
      logic [23:0] r;
      for (int k = 0; k < 24; k++) r[23-k] = f[1+k];
      return r;
   endfunction

   function automatic logic [23:0] get_right(input logic [63:0] f);
      logic [23:0] r;
      for (int k = 0; k < 24; k++) r[23-k] = f[33+k];
      return r;
   endfunction

   task automatic wait_fs(input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_in);
         if (frame_start_out) return;
      end
      check({tag, " frame_start timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_frames(input int n, input string tag);
      int target;
      target = frames + n;
      for (int i = 0; i < n * 2048 + 2100; i++) begin
         @(negedge clk_in);
         if (frames >= target) return;
      end
      check({tag, " frame capture timeout"}, 64'd0, 64'd1);
   endtask

   task automatic send(input logic [23:0] l, input logic [23:0] r, input string tag);
      check({tag, " ready before send"}, ready_out, 1'b1);
      left_in = l; right_in = r; valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
   endtask

   int lat, a0, r0, u0, f0;

   initial begin
      // Reset state
      repeat (5) @(negedge clk_in);
      check("rst sclk", sclk_out, 1'b0);
      check("rst ws", ws_out, 1'b1);
      check("rst sdata", sdata_out, 1'b0);
      check("rst ready", ready_out, 1'b1);
      check("rst frame_start", frame_start_out, 1'b0);
      check("rst underrun", underrun_out, 1'b0);

      // Idle run: first load 32 cycles after release, underrun every frame
      rst_in = 1'b1;
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk_in);
         if (frame_start_out) begin lat = i; break; end
      end
      check("idle first load latency", lat, 32);
      check("idle first underrun", underrun_out, 1'b1);
      wait_fs("idle");
      u0 = und_cnt; f0 = fs_cnt;
      repeat (3 * 2048) @(negedge clk_in);
      check("idle underrun count", und_cnt - u0, 3);
      check("idle frame_start count", fs_cnt - f0, 3);
      check("sclk period", sclk_per, 32);
      check("ws period", ws_per, 2048);
      check("idle sdata zero", last_frame, 64'd0);

      // Pattern recovered by the receive model
      wait_fs("pattern");
      send(24'hA5A5A5, 24'h3C3C3C, "pattern");
      wait_frames(2, "pattern");
      check("pattern left", get_left(last_frame), 24'hA5A5A5);
      check("pattern right", get_right(last_frame), 24'h3C3C3C);
      check("pattern left pad", last_frame[31:25], 7'd0);
      check("pattern right pad", last_frame[63:57], 7'd0);
      check("pattern lead bits", {last_frame[32], last_frame[0]}, 2'b00);

      // Continuous valid: one accept per frame, ready high one cycle per frame
      wait_fs("stream");
      left_in = 24'h123456; right_in = 24'h654321; valid_in = 1'b1;
      a0 = acc_cnt; r0 = rdy_hi_cnt;
      @(negedge clk_in);
      u0 = und_cnt;
      repeat (999) @(negedge clk_in);
      check("stream ready low mid-frame", ready_out, 1'b0);
      repeat (5144) @(negedge clk_in);
      valid_in = 1'b0;
      check("stream load timing", frame_start_out, 1'b1);
      check("stream accept count", acc_cnt - a0, 3);
      check("stream ready-high cycles", rdy_hi_cnt - r0, 3);
      check("stream no underrun", und_cnt - u0, 0);
      wait_frames(1, "stream");
      check("stream left", get_left(last_frame), 24'h123456);
      check("stream right", get_right(last_frame), 24'h654321);

      // valid_in in the exact load cycle with the buffer full
      wait_fs("loadcyc");
      a0 = acc_cnt;
      send(24'h111111, 24'h999999, "loadcyc");
      repeat (2046) @(negedge clk_in);
      left_in = 24'h222222; right_in = 24'hAAAAAA; valid_in = 1'b1;
      @(negedge clk_in);
      check("loadcyc frame_start", frame_start_out, 1'b1);
      check("loadcyc no underrun", underrun_out, 1'b0);
      check("loadcyc ready after load", ready_out, 1'b1);
      check("loadcyc not accepted", acc_cnt - a0, 1);
      @(negedge clk_in);
      valid_in = 1'b0;
      check("loadcyc accepted next cycle", acc_cnt - a0, 2);
      check("loadcyc ready low", ready_out, 1'b0);
      wait_frames(1, "loadcyc");
      check("loadcyc frame1 left", get_left(last_frame), 24'h111111);
      wait_frames(1, "loadcyc");
      check("loadcyc frame2 left", get_left(last_frame), 24'h222222);
      check("loadcyc frame2 right", get_right(last_frame), 24'hAAAAAA);

      // Most negative sample
      wait_fs("neg");
      send(24'h800000, 24'h7FFFFF, "neg");
      wait_frames(2, "neg");
      check("neg msb at b1", last_frame[1], 1'b1);
      check("neg 23 zeros", last_frame[24:2], 23'd0);
      check("neg right", get_right(last_frame), 24'h7FFFFF);

      // Reset at b=40 with a frame in flight and the buffer full
      wait_fs("midrst");
      send(24'hAAAAAA, 24'h555555, "midrst");
      wait_fs("midrst");
      send(24'h0F0F0F, 24'hF0F0F0, "midrst");
      repeat (1299) @(negedge clk_in);
      check("midrst pre sclk", sclk_out, 1'b1);
      check("midrst pre ws", ws_out, 1'b1);
      check("midrst pre sdata b40", sdata_out, 1'b1);
      check("midrst pre ready", ready_out, 1'b0);
      rst_in = 1'b0;
      #1;
      check("midrst sclk", sclk_out, 1'b0);
      check("midrst ws", ws_out, 1'b1);
      check("midrst sdata", sdata_out, 1'b0);
      check("midrst ready", ready_out, 1'b1);
      check("midrst pulses", {frame_start_out, underrun_out}, 2'b00);
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk_in);
         if (frame_start_out) begin lat = i; break; end
      end
      check("midrst restart latency", lat, 32);
      check("midrst buffer discarded", underrun_out, 1'b1);
      wait_frames(1, "midrst");
      check("midrst first frame zero", last_frame, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
